// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: RV32 load/store unit front-end driving a single-port word-wide data memory.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (when defined, misaligned halfword/word accesses fault).
// Ports:
//   Clk_Core, Rst_Core_N           core clock, asynchronous active-low reset
//   Req_Valid/Req_Ready            request handshake (Ready only in IDLE)
//   Req_Write/Req_Funct3           store flag and RV32 funct3
//   Req_Addr/Req_Wdata             byte address, right-aligned store data
//   Rsp_Valid/Rsp_Rdata/Rsp_Err    one-cycle response strobe, formatted load data, access fault
//   Read_Ctrl/Write_Ctrl           memory read strobe, byte write enables (ACCESS only)
//   Mem_Data_Address/Mem_Data_Write word address and lane-replicated store data
//   Mem_Data_Read                  memory read data, valid the cycle after Read_Ctrl
module lsu_mem_ctrl #(
    parameter int MEM_SIZE = 16384
) (
    input  logic        Clk_Core,
    input  logic        Rst_Core_N,
    input  logic        Req_Valid,
    output logic        Req_Ready,
    input  logic        Req_Write,
    input  logic [2:0]  Req_Funct3,
    input  logic [31:0] Req_Addr,
    input  logic [31:0] Req_Wdata,
    output logic        Rsp_Valid,
    output logic [31:0] Rsp_Rdata,
    output logic        Rsp_Err,
    output logic        Read_Ctrl,
    output logic [3:0]  Write_Ctrl,
    output logic [31:0] Mem_Data_Address,
    output logic [31:0] Mem_Data_Write,
    input  logic [31:0] Mem_Data_Read
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE);

    logic [1:0]  state;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        illegal;
    logic        oob;
    logic        misalign;
    logic        fault;
    logic [3:0]  mask;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) begin
            state <= IDLE;
            wr    <= 1'b0;
            f3    <= 3'b000;
            addr  <= 32'h0;
            wdata <= 32'h0;
        end else begin
            state <= state == IDLE ? (Req_Valid ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
            if (state == IDLE && Req_Valid) begin
                wr    <= Req_Write;
                f3    <= Req_Funct3;
                addr  <= Req_Addr;
                wdata <= Req_Wdata;
            end
        end
    end

    // Fault is derived from the captured request, so it stays stable through ACCESS and RESP.
    always_comb begin
        illegal = wr ? (f3 > 3'b010) : (f3 == 3'b011 || f3[2:1] == 2'b11);
        oob     = {2'b00, addr[31:2]} >= MEM_LIMIT;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = (f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
        fault = illegal | oob | misalign;
        mask  = f3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
                f3[1:0] == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    end

    // Address and store data come straight from the request registers, so they
    // appear in ACCESS, hold afterwards and clear with reset.
    assign Mem_Data_Address = {addr[31:2], 2'b00};
    assign Mem_Data_Write   = f3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                              f3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;

    // Strobes decode from state so an asynchronous reset drops them immediately.
    assign Read_Ctrl  = state == ACCESS && !wr && !fault;
    assign Write_Ctrl = (state == ACCESS && wr && !fault) ? mask : 4'b0000;

    always_comb begin
        ld_byte = Mem_Data_Read[{addr[1:0], 3'b000} +: 8];
        ld_half = addr[1] ? Mem_Data_Read[31:16] : Mem_Data_Read[15:0];
        ld_data = f3[1:0] == 2'b00 ? {{24{ld_byte[7] & ~f3[2]}}, ld_byte} :
                  f3[1:0] == 2'b01 ? {{16{ld_half[15] & ~f3[2]}}, ld_half} : Mem_Data_Read;
    end

    assign Req_Ready = state == IDLE;
    assign Rsp_Valid = state == RESP;
    assign Rsp_Err   = state == RESP && fault;
    assign Rsp_Rdata = (state == RESP && !wr && !fault) ? ld_data : 32'h0;
endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_SIZE, default 16384, giving data memory depth in 32-bit words.
REQ-002 The block SHALL have port Clk_Core, input, 1 bit: the single core clock.
REQ-003 The block SHALL have port Rst_Core_N, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the following core-side ports:
- Req_Valid, input, 1: request present.
- Req_Ready, output, 1: block can accept a request.
- Req_Write, input, 1: 1 = store, 0 = load.
- Req_Funct3, input, 3: RV32 load/store funct3.
- Req_Addr, input, 32: byte address.
- Req_Wdata, input, 32: store data, right-aligned.
- Rsp_Valid, output, 1: one-cycle response strobe.
- Rsp_Rdata, output, 32: formatted load data.
- Rsp_Err, output, 1: access fault.
REQ-005 The block SHALL have the following memory-side ports:
- Read_Ctrl, output, 1.
- Write_Ctrl, output, 4: byte enables.
- Mem_Data_Address, output, 32.
- Mem_Data_Write, output, 32.
- Mem_Data_Read, input, 32: data is valid one cycle after the Read_Ctrl edge.

Function
REQ-006 The FSM SHALL have exactly three states (IDLE, ACCESS, RESP) with transitions:
- IDLE->ACCESS on Req_Valid & Req_Ready.
- ACCESS->RESP unconditionally.
- RESP->IDLE unconditionally.
REQ-007 Req_Ready SHALL be 1 only in IDLE; when Req_Ready=0 the block SHALL ignore Req_Valid.
REQ-008 On acceptance the block SHALL register Req_Write, Req_Funct3, Req_Addr and Req_Wdata; later changes on the request inputs SHALL have no effect on the accepted request.
REQ-009 Rsp_Valid SHALL be 1 for exactly one cycle (RESP), two cycles after the acceptance edge; there is no response backpressure, and the next acceptance is possible at the earliest in the cycle after RESP.
REQ-010 Memory drive in ACCESS:
- Mem_Data_Address = {addr[31:2], 2'b00}.
- Read_Ctrl = 1 for a legal load.
- Write_Ctrl = lane mask for a legal store.
- In IDLE and RESP, Read_Ctrl=0 and Write_Ctrl=4'b0000; Mem_Data_Address and Mem_Data_Write hold their last values.
REQ-011 Store formatting:
- SB (000): Wdata[7:0] replicated to all four lanes, Write_Ctrl = 4'b0001 << addr[1:0].
- SH (001): Wdata[15:0] replicated to both halves, Write_Ctrl = 4'b0011 when addr[1]=0, 4'b1100 when addr[1]=1.
- SW (010): Wdata unchanged, Write_Ctrl = 4'b1111.
REQ-012 Load formatting in RESP, from Mem_Data_Read:
- LB (000) / LBU (100): byte lane addr[1:0], sign-extended / zero-extended.
- LH (001) / LHU (101): half lane addr[1], sign-extended / zero-extended.
- LW (010): the full word.
REQ-013 A request SHALL be faulted when:
- funct3 is illegal (loads 011/110/111; stores >=011), or
- the word index addr[31:2] >= MEM_SIZE.
REQ-014 A faulted request SHALL:
- assert no memory strobe in ACCESS;
- respond in RESP with Rsp_Err=1 and Rsp_Rdata=0, at the same latency as a legal request.
REQ-015 For a store, and for any response with Rsp_Err=1, Rsp_Rdata SHALL be 0; Rsp_Rdata and Rsp_Err SHALL be 0 outside RESP.

Reset
REQ-016 Asserting Rst_Core_N low SHALL immediately force:
- state to IDLE;
- Read_Ctrl=0, Write_Ctrl=0;
- Mem_Data_Address=0, Mem_Data_Write=0;
- Rsp_Valid=0, Rsp_Rdata=0, Rsp_Err=0;
- all request registers to 0.
REQ-017 Req_Ready SHALL be 1 while reset is asserted and in the first cycle after release.
REQ-018 Reset asserted in ACCESS or RESP SHALL abort the access (strobes drop without waiting for a clock edge), and the pending response SHALL never be issued.

Configuration
REQ-019 With macro LSU_MISALIGN_TRAP_EN defined:
- LH/LHU/SH with addr[0]=1 SHALL be faulted per REQ-014.
- LW/SW with addr[1:0]!=00 SHALL be faulted per REQ-014.
REQ-020 With LSU_MISALIGN_TRAP_EN undefined:
- The block SHALL never fault on alignment.
- Halfword accesses SHALL ignore addr[0]; word accesses SHALL ignore addr[1:0].

Verification
REQ-021 Scenario SW, then LW:
- Stimulus: SW addr 0x100, data 0xDEADBEEF; then LW addr 0x100.
- Required response: Write_Ctrl=1111 and Mem_Data_Address=0x100 in ACCESS; LW returns Rsp_Rdata=0xDEADBEEF with Rsp_Valid two cycles after acceptance.
REQ-022 Scenario SB, then LB/LBU:
- Stimulus: SB addr 0x103, data 0x80; then LB addr 0x103; then LBU addr 0x103.
- Required response: Write_Ctrl=1000 and Mem_Data_Write=0x80808080; LB returns 0xFFFFFF80; LBU returns 0x00000080.
REQ-023 Scenario SH, then LH:
- Stimulus: SH addr 0x202, data 0x1234ABCD; then LH addr 0x202.
- Required response: Write_Ctrl=1100 and Mem_Data_Write=0xABCDABCD; LH returns 0xFFFFABCD.
REQ-024 Scenario faults:
- Stimulus: LW addr 0x0001_0000 (MEM_SIZE=16384, word index 16384); then funct3=011 load.
- Required response: each gives Read_Ctrl=0 throughout and Rsp_Err=1 with Rsp_Rdata=0.
- Additionally with LSU_MISALIGN_TRAP_EN: LW addr 0x102 gives Rsp_Err=1; without it, it reads word 0x100.
REQ-025 Scenario reset mid-operation:
- Stimulus: accept a load, then pull Rst_Core_N low during ACCESS.
- Required response: Read_Ctrl falls before the next edge; no Rsp_Valid occurs; Req_Ready=1 after release.
REQ-026 Scenario back-to-back requests:
- Stimulus: Req_Valid held high for 6 cycles with changing request inputs.
- Required response: exactly 2 acceptances (cycles 0 and 3); each response corresponds to the inputs sampled at its acceptance.
